// File: rtl/la_pipebuf_pkg.sv
// la_pipebuf_pkg: shared constants and the count-width helper for la_pipebuf.
package la_pipebuf_pkg;

   // Deepest chain the block is meant to be built with.
   localparam int LA_PIPEBUF_MAXDEPTH = 16;

   // Width needed to hold an occupancy of 0..depth.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/la_pipebuf_if.sv
// la_pipebuf_if: valid/ready handshake on both sides of the buffer plus the
// occupancy count. The buffer itself takes the slave view.
interface la_pipebuf_if
   import la_pipebuf_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 2
);
   localparam int CW = count_width(DEPTH);

   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [CW-1:0] count;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, count
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, count
   );
endinterface

// File: rtl/la_pipebuf_stage.sv
// la_pipebuf_stage: one register slot of the chain (valid bit + data word).
// load brings a new word in; unload lets the held word leave with no
// replacement. load wins when both happen on the same edge.
module la_pipebuf_stage
   import la_pipebuf_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          flush,
   input  logic          load,
   input  logic          unload,
   input  logic [DW-1:0] d,
   output logic          valid,
   output logic [DW-1:0] data
);

   // Slot state; reset beats flush, flush beats any transfer.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (flush)       valid <= 1'b0;
         else if (load)   valid <= 1'b1;
         else if (unload) valid <= 1'b0;
         if (load) data <= d;
      end
   end

endmodule

// File: rtl/la_pipebuf.sv
// la_pipebuf: DEPTH-stage valid/ready pipeline buffer with collapsing bubbles
// and a registered occupancy count.
// Optional feature: define LA_PIPEBUF_CLEAR_EN to make the clear input flush
// all stages; otherwise clear is ignored and no flush logic exists.
module la_pipebuf
   import la_pipebuf_pkg::*;
#(
   parameter     PROP  = "DEFAULT",
   parameter int DW    = 8,
   parameter int DEPTH = 2
) (
   input logic         clk,
   input logic         nreset,
   input logic         clear,
   la_pipebuf_if.slave bus
);
   localparam int CW = count_width(DEPTH);

   logic          flush;
   logic          in_xfer;
   logic          out_xfer;
   logic [CW-1:0] cnt;

`ifdef LA_PIPEBUF_CLEAR_EN
   assign flush = clear;
`else
   logic unused_clear;
   assign unused_clear = clear;
   assign flush        = 1'b0;
`endif

   // Each stage advances when it is empty or the stage after it is taking its
   // word; the ready path therefore ripples back from out_ready to in_ready.
   for (genvar k = 0; k < DEPTH; k++) begin : stg
      logic          v, up_valid, dn_ready, adv;
      logic [DW-1:0] q, up_data;

      if (k == 0) begin : g_src
         assign up_valid = bus.in_valid & ~flush;
         assign up_data  = bus.in_data;
      end else begin : g_src
         assign up_valid = stg[k-1].v;
         assign up_data  = stg[k-1].q;
      end

      if (k == DEPTH - 1) begin : g_dst
         assign dn_ready = bus.out_ready;
      end else begin : g_dst
         assign dn_ready = stg[k+1].adv;
      end

      assign adv = ~v | dn_ready;

      la_pipebuf_stage #(.DW(DW)) u_stage (
         .clk    (clk),
         .nreset (nreset),
         .flush  (flush),
         .load   (adv & up_valid),
         .unload (v & dn_ready),
         .d      (up_data),
         .valid  (v),
         .data   (q)
      );
   end

   assign bus.in_ready  = stg[0].adv & ~flush;
   assign bus.out_valid = stg[DEPTH-1].v;
   assign bus.out_data  = stg[DEPTH-1].q;

   assign in_xfer  = bus.in_valid & bus.in_ready;
   assign out_xfer = bus.out_valid & bus.out_ready;

   // Occupancy: +1 on input-only, -1 on output-only, hold otherwise.
   always_ff @(posedge clk) begin
      if (!nreset)                 cnt <= '0;
      else if (flush)              cnt <= '0;
      else if (in_xfer & ~out_xfer) cnt <= cnt + CW'(1);
      else if (~in_xfer & out_xfer) cnt <= cnt - CW'(1);
   end

   assign bus.count = cnt;

endmodule
